// File: rtl/pattern_pkg.sv
// pattern_pkg: pattern-select encodings, constant-mode default and the PRBS-15 word step.
// Shared by the pattern source and the checker so the two cannot disagree on the sequence.
package pattern_pkg;

    typedef enum logic [1:0] {
        SEL_CNT    = 2'b00,
        SEL_PRBS   = 2'b01,
        SEL_CONST  = 2'b10,
        SEL_CONSTB = 2'b11
    } sel_e;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } chk_state_e;

    localparam logic [15:0] CONST_VAL_DEFAULT = 16'hAAAA;

    // x^15+x^14+1, MSB-first: s[31] is the oldest bit of prev, each new bit is b[n-15]^b[n-14].
    function automatic logic [15:0] prbs15_next16(input logic [15:0] prev);
        logic [31:0] s;
        s = {prev, 16'h0000};
        for (int i = 0; i < 16; i++) begin
            s[15-i] = s[30-i] ^ s[29-i];
        end
        return s[15:0];
    endfunction

endpackage

// File: rtl/pattern_expect.sv
// pattern_expect: registered mux of the four expected-word generators.
// Loads the word that should follow prev, ready for comparison on the next accepted word.
module pattern_expect
    import pattern_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] CONST_VAL = CONST_VAL_DEFAULT
) (
    input  logic              clk1280,
    input  logic              rst,
    input  logic              load,
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] prev,
    output logic [DATA_W-1:0] expected
);

    logic [DATA_W-1:0] exp_d;

    // NOTE: the default assignment first means every path drives exp_d, so no latch is inferred.
    always_comb begin
        exp_d = '0;
        unique case (sel)
            SEL_CNT:    exp_d = prev + DATA_W'(1);
            SEL_PRBS:   exp_d = prbs15_next16(prev);
            SEL_CONST:  exp_d = CONST_VAL;
            SEL_CONSTB: exp_d = ~CONST_VAL;
        endcase
    end

    always_ff @(posedge clk1280) begin
        if (rst) begin
            expected <= '0;
        end else if (load) begin
            expected <= exp_d;
        end
    end

endmodule

// File: rtl/pattern_checker.sv
// pattern_checker: self-synchronising receive checker for the FMCA[15:0] test-pattern stream.
// Define PATTERN_CHECKER_BITERR_EN to add the bit_err_cnt output (popcount of errored bits).
module pattern_checker
    import pattern_pkg::*;
#(
    parameter int                DATA_W        = 16,
    parameter int                ERR_CNT_W     = 32,
    parameter logic [DATA_W-1:0] CONST_VAL     = CONST_VAL_DEFAULT,
    parameter int                LOCK_THRESH   = 8,
    parameter int                UNLOCK_THRESH = 4
) (
    input  logic                 clk1280,
    input  logic                 rst,
    input  logic [1:0]           sel,
    input  logic [DATA_W-1:0]    rx_data,
    input  logic                 rx_valid,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err_flag,
    output logic [ERR_CNT_W-1:0] err_cnt
`ifdef PATTERN_CHECKER_BITERR_EN
    ,
    output logic [ERR_CNT_W-1:0] bit_err_cnt
`endif
);

    localparam int MW = $clog2(LOCK_THRESH + 1);
    localparam int NW = $clog2(UNLOCK_THRESH + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_THRESH - 1);
    localparam logic [NW-1:0] MISS_LAST  = NW'(UNLOCK_THRESH - 1);

    logic [1:0]        sel_q;
    logic              sel_chg;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] exp_q;
    logic              have_rx;
    logic              prev_vld;
    logic              loaded_q;
    logic              chk;
    logic              mismatch;
    logic              err_hit;
    chk_state_e        state, state_nxt;
    logic [MW-1:0]     match_cnt, match_nxt;
    logic [NW-1:0]     miss_cnt, miss_nxt;

    assign sel_chg = (sel != sel_q);

    // A word arriving together with a sel change is dropped; acquisition restarts on the next one.
    always_ff @(posedge clk1280) begin
        if (rst) begin
            sel_q    <= sel;
            rx_q     <= '0;
            have_rx  <= 1'b0;
            prev_vld <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            sel_q <= sel;
            if (sel_chg) begin
                have_rx  <= 1'b0;
                prev_vld <= 1'b0;
                loaded_q <= 1'b0;
            end else begin
                loaded_q <= rx_valid;
                if (rx_valid) begin
                    rx_q     <= rx_data;
                    have_rx  <= 1'b1;
                    prev_vld <= have_rx;
                end
            end
        end
    end

    pattern_expect #(
        .DATA_W    (DATA_W),
        .CONST_VAL (CONST_VAL)
    ) u_expect (
        .clk1280  (clk1280),
        .rst      (rst),
        .load     (rx_valid & ~sel_chg),
        .sel      (sel),
        .prev     (rx_q),
        .expected (exp_q)
    );

    assign chk      = loaded_q & prev_vld & ~sel_chg;
    assign mismatch = (rx_q != exp_q);

    always_ff @(posedge clk1280) begin
        if (rst) begin
            state     <= ST_SEARCH;
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        if (sel_chg) begin
            state_nxt = ST_SEARCH;
            match_nxt = '0;
            miss_nxt  = '0;
        end else if (chk) begin
            unique case (state)
                ST_SEARCH: begin
                    if (mismatch) begin
                        match_nxt = '0;
                    end else if (match_cnt == MATCH_LAST) begin
                        state_nxt = ST_LOCKED;
                        match_nxt = '0;
                        miss_nxt  = '0;
                    end else begin
                        match_nxt = match_cnt + MW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!mismatch) begin
                        miss_nxt = '0;
                    end else if (miss_cnt == MISS_LAST) begin
                        state_nxt = ST_SEARCH;
                        match_nxt = '0;
                        miss_nxt  = '0;
                    end else begin
                        miss_nxt = miss_cnt + NW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        locked  = (state == ST_LOCKED);
        err_hit = chk & mismatch & locked;
    end

    // clr_cnt takes priority over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk1280) begin
        if (rst) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end else begin
            err_flag <= err_hit;
            if (clr_cnt) begin
                err_cnt <= '0;
            end else if (err_hit && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

`ifdef PATTERN_CHECKER_BITERR_EN
    localparam int PW = $clog2(DATA_W + 1);

    logic [PW-1:0]      pop_q;
    logic               pop_vld;
    logic [ERR_CNT_W:0] bit_sum;

    always_ff @(posedge clk1280) begin
        if (rst) begin
            pop_q   <= '0;
            pop_vld <= 1'b0;
        end else begin
            pop_q   <= PW'($countones(rx_q ^ exp_q));
            pop_vld <= err_hit;
        end
    end

    assign bit_sum = {1'b0, bit_err_cnt} + (ERR_CNT_W + 1)'(pop_q);

    always_ff @(posedge clk1280) begin
        if (rst) begin
            bit_err_cnt <= '0;
        end else if (clr_cnt) begin
            bit_err_cnt <= '0;
        end else if (pop_vld) begin
            bit_err_cnt <= bit_sum[ERR_CNT_W] ? '1 : bit_sum[ERR_CNT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_pattern_checker.sv
// tb_pattern_checker: scoreboard bench for pattern_checker against a pattern-rule reference model.
// Build with PATTERN_CHECKER_BITERR_EN defined to also check bit_err_cnt.
module tb_pattern_checker;

    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk1280;
    logic          rst;
    logic [1:0]    sel;
    logic [15:0]   rx_data;
    logic          rx_valid;
    logic          clr_cnt;
    logic          locked;
    logic          err_flag;
    logic [CW-1:0] err_cnt;
`ifdef PATTERN_CHECKER_BITERR_EN
    logic [CW-1:0] bit_err_cnt;
`endif

    pattern_checker #(
        .DATA_W        (16),
        .ERR_CNT_W     (CW),
        .CONST_VAL     (16'hAAAA),
        .LOCK_THRESH   (8),
        .UNLOCK_THRESH (4)
    ) dut (
        .clk1280  (clk1280),
        .rst      (rst),
        .sel      (sel),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .clr_cnt  (clr_cnt),
        .locked   (locked),
        .err_flag (err_flag),
        .err_cnt  (err_cnt)
`ifdef PATTERN_CHECKER_BITERR_EN
        ,
        .bit_err_cnt (bit_err_cnt)
`endif
    );

    initial clk1280 = 1'b0;
    always #5 clk1280 = ~clk1280;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pattern rules written straight from the definition: counter, PRBS bit recurrence, constants.
    function automatic logic [15:0] ref_next(input logic [1:0] s, input logic [15:0] p);
        bit          b[$];
        logic [15:0] w;
        w = '0;
        case (s)
            2'd0: w = p + 16'd1;
            2'd1: begin
                for (int j = 15; j >= 0; j--) b.push_back(p[j]);
                for (int i = 0; i < 16; i++) b.push_back(b[b.size()-15] ^ b[b.size()-14]);
                for (int i = 0; i < 16; i++) w[15-i] = b[16+i];
            end
            2'd2: w = 16'hAAAA;
            default: w = 16'h5555;
        endcase
        return w;
    endfunction

    typedef struct {
        logic          lk;
        logic          ef;
        logic [CW-1:0] ec;
        logic [CW-1:0] bc;
    } exp_t;

    exp_t sb[$];

    // Reference model state: status flags and plain integer counts.
    bit          m_locked;
    int          m_match, m_miss, m_err, m_bit;
    logic [1:0]  m_sel_prev;
    bit          m_have_prev;
    logic [15:0] m_prev;
    bit          pend_valid, pend_mis;
    int          pend_pop;
    bit          bit_pend;
    int          bit_pend_pop;

    task automatic model_edge();
        bit   hit;
        bit   sel_chg;
        exp_t e;
        logic [15:0] want;
        hit = 0;
        if (rst) begin
            m_locked = 0; m_match = 0; m_miss = 0; m_err = 0; m_bit = 0;
            m_have_prev = 0; pend_valid = 0; bit_pend = 0;
            m_sel_prev = sel;
        end else begin
            sel_chg    = (sel != m_sel_prev);
            m_sel_prev = sel;
            if (clr_cnt) m_bit = 0;
            else if (bit_pend) m_bit = (m_bit + bit_pend_pop > CMAX) ? CMAX : m_bit + bit_pend_pop;
            if (sel_chg) begin
                m_locked = 0; m_match = 0; m_miss = 0;
                m_have_prev = 0; pend_valid = 0;
            end else begin
                if (pend_valid) begin
                    if (!m_locked) begin
                        if (pend_mis) m_match = 0;
                        else begin
                            m_match++;
                            if (m_match == 8) begin m_locked = 1; m_match = 0; m_miss = 0; end
                        end
                    end else begin
                        if (pend_mis) begin
                            hit = 1;
                            m_miss++;
                            if (m_miss == 4) begin m_locked = 0; m_match = 0; m_miss = 0; end
                        end else m_miss = 0;
                    end
                end
                pend_valid = 0;
                if (rx_valid) begin
                    if (m_have_prev) begin
                        want       = ref_next(sel, m_prev);
                        pend_valid = 1;
                        pend_mis   = (rx_data != want);
                        pend_pop   = $countones(rx_data ^ want);
                    end
                    m_prev      = rx_data;
                    m_have_prev = 1;
                end
            end
            if (clr_cnt) m_err = 0;
            else if (hit && m_err < CMAX) m_err++;
            bit_pend     = hit;
            bit_pend_pop = pend_pop;
        end
        e.lk = m_locked;
        e.ef = hit;
        e.ec = CW'(m_err);
        e.bc = CW'(m_bit);
        sb.push_back(e);
    endtask

    // Monitor: one expected record per clock edge, compared half a cycle later.
    always @(negedge clk1280) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("mon_locked", locked, e.lk);
            check("mon_err_flag", err_flag, e.ef);
            check("mon_err_cnt", err_cnt, e.ec);
`ifdef PATTERN_CHECKER_BITERR_EN
            check("mon_bit_err_cnt", bit_err_cnt, e.bc);
`endif
        end
    end

    logic       rst_nxt, clr_nxt;
    logic [1:0] sel_nxt;

    task automatic cyc(input logic v, input logic [15:0] d);
        @(negedge clk1280);
        rst      = rst_nxt;
        sel      = sel_nxt;
        clr_cnt  = clr_nxt;
        rx_valid = v;
        rx_data  = d;
        @(posedge clk1280);
        model_edge();
    endtask

    task automatic clr_pulse();
        clr_nxt = 1'b1;
        cyc(1'b0, 16'h0);
        clr_nxt = 1'b0;
    endtask

    task automatic burst(input int n, input logic [15:0] d);
        for (int i = 0; i < n; i++) cyc(1'b1, d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [15:0] w;
    logic [15:0] gen_cur;

    initial begin
        rst = 1'b1; sel = 2'd0; rx_valid = 1'b0; rx_data = '0; clr_cnt = 1'b0;
        rst_nxt = 1'b1; sel_nxt = 2'd0; clr_nxt = 1'b0;
        repeat (2) cyc(1'b0, 16'h0);
        rst_nxt = 1'b0;
        #1;
        check("reset_locked", locked, 1'b0);
        check("reset_err_flag", err_flag, 1'b0);
        check("reset_err_cnt", err_cnt, '0);

        // Counter stream through the FFFF->0000 wrap.
        for (int i = 0; i < 20; i++) cyc(1'b1, 16'(16'hFFF0 + i));
        cyc(1'b0, 16'h0);
        #1;
        check("cnt_locked", locked, 1'b1);
        check("cnt_err_cnt", err_cnt, 8'd0);

        // PRBS-15 from 0x7FFF with bit 3 flipped in one word.
        sel_nxt = 2'd1;
        cyc(1'b0, 16'h0);
        w = 16'h7FFF;
        for (int i = 0; i < 12; i++) begin cyc(1'b1, w); w = ref_next(2'd1, w); end
        cyc(1'b1, w ^ 16'h0008);
        w = ref_next(2'd1, w);
        for (int i = 0; i < 4; i++) begin cyc(1'b1, w); w = ref_next(2'd1, w); end
        cyc(1'b0, 16'h0);
        #1;
        check("prbs_locked", locked, 1'b1);
        check("prbs_err_cnt", err_cnt, 8'd2);

        // Const mode: three errors keep lock, the fourth drops it, eight good words relock.
        sel_nxt = 2'd2;
        cyc(1'b0, 16'h0);
        clr_pulse();
        burst(10, 16'hAAAA);
        burst(3, 16'h5555);
        cyc(1'b0, 16'h0);
        #1;
        check("const_3bad_locked", locked, 1'b1);
        check("const_3bad_err_cnt", err_cnt, 8'd3);
        burst(1, 16'h5555);
        cyc(1'b0, 16'h0);
        #1;
        check("const_4bad_locked", locked, 1'b0);
        check("const_4bad_err_cnt", err_cnt, 8'd4);
        burst(7, 16'hAAAA);
        cyc(1'b0, 16'h0);
        #1;
        check("const_7good_locked", locked, 1'b0);
        burst(1, 16'hAAAA);
        cyc(1'b0, 16'h0);
        #1;
        check("const_relock", locked, 1'b1);

        // sel 10->11 mid-stream, then a gapped 0x5555 stream.
        sel_nxt = 2'd3;
        cyc(1'b1, 16'h5555);
        #1;
        check("selchg_locked", locked, 1'b0);
        check("selchg_err_cnt", err_cnt, 8'd4);
        for (int i = 0; i < 9; i++) begin cyc(1'b1, 16'h5555); cyc(1'b0, 16'h0); end
        #1;
        check("gapped_locked", locked, 1'b1);
        check("gapped_err_cnt", err_cnt, 8'd4);

        // clr_cnt on the same edge as an error, then saturation.
        cyc(1'b1, 16'hAAAA);
        clr_nxt = 1'b1;
        cyc(1'b1, 16'h5555);
        clr_nxt = 1'b0;
        #1;
        check("clr_vs_err_flag", err_flag, 1'b1);
        check("clr_vs_err_cnt", err_cnt, 8'd0);
        for (int i = 0; i < 260; i++) begin cyc(1'b1, 16'hAAAA); cyc(1'b1, 16'h5555); end
        cyc(1'b0, 16'h0);
        #1;
        check("sat_err_cnt", err_cnt, 8'hFF);
        check("sat_locked", locked, 1'b1);
        cyc(1'b1, 16'hAAAA);
        cyc(1'b0, 16'h0);
        #1;
        check("sat_hold_flag", err_flag, 1'b1);
        check("sat_hold_cnt", err_cnt, 8'hFF);
        cyc(1'b1, 16'h5555);

        // Bit-error count for a 4-bit corruption, then reset mid-stream.
        sel_nxt = 2'd2;
        cyc(1'b0, 16'h0);
        clr_pulse();
        burst(9, 16'hAAAA);
        cyc(1'b1, 16'hAAA5);
        cyc(1'b1, 16'hAAAA);
        cyc(1'b0, 16'h0);
        #1;
        check("biterr_err_cnt", err_cnt, 8'd1);
`ifdef PATTERN_CHECKER_BITERR_EN
        check("biterr_bit_cnt", bit_err_cnt, 8'd4);
`endif
        cyc(1'b1, 16'h5555);
        rst_nxt = 1'b1;
        cyc(1'b1, 16'hAAAA);
        rst_nxt = 1'b0;
        #1;
        check("midrst_locked", locked, 1'b0);
        check("midrst_err_flag", err_flag, 1'b0);
        check("midrst_err_cnt", err_cnt, 8'd0);
`ifdef PATTERN_CHECKER_BITERR_EN
        check("midrst_bit_cnt", bit_err_cnt, 8'd0);
`endif

        // Randomised traffic: gaps, corrupted words, sel changes, clears and resets.
        gen_cur = 16'h1234;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(199) == 0) begin
                sel_nxt = 2'($urandom_range(3));
                gen_cur = 16'($urandom) | 16'h0001;
            end
            clr_nxt = ($urandom_range(99) == 0);
            rst_nxt = ($urandom_range(799) == 0);
            if ($urandom_range(3) != 0) begin
                w = gen_cur;
                if ($urandom_range(32) == 0) w = w ^ 16'(1 << $urandom_range(15));
                cyc(1'b1, w);
                gen_cur = ref_next(sel_nxt, gen_cur);
            end else begin
                cyc(1'b0, 16'h0);
            end
        end
        clr_nxt = 1'b0;
        rst_nxt = 1'b0;
        repeat (3) cyc(1'b0, 16'h0);
        @(negedge clk1280);
        #1;
        check("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
